// File: rtl/hex_scan_sequencer.sv
// hex_scan_sequencer: raster-scans a hex decoder via x/y, waits for its colour to settle, and streams pixels out over valid/ready.
// Optional HEX_SCAN_AUTO_REFRESH_EN re-arms a frame on every frame_done for continuous scanning.
module hex_scan_sequencer #(
  parameter int C_data_len   = 64,
  parameter int C_color_bits = 16,
  parameter int C_x_bits     = 7,
  parameter int C_y_bits     = 7,
  parameter int C_x_size     = 128,
  parameter int C_y_size     = 64,
  parameter int C_settle     = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [C_data_len-1:0]   data_in,
  input  logic                    refresh,
  output logic [C_x_bits-1:0]     x,
  output logic [C_y_bits-1:0]     y,
  output logic [C_data_len-1:0]   data_snap,
  input  logic [C_color_bits-1:0] color_in,
  output logic [C_color_bits-1:0] pixel_data,
  output logic                    pixel_valid,
  input  logic                    pixel_ready,
  output logic                    frame_start,
  output logic                    frame_done,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;
  localparam int CW = (C_settle > 1) ? $clog2(C_settle) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(C_settle - 1);
  localparam logic [C_x_bits-1:0] X_LAST = C_x_bits'(C_x_size - 1);
  localparam logic [C_y_bits-1:0] Y_LAST = C_y_bits'(C_y_size - 1);
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [C_x_bits-1:0]     x_q, x_d;
  logic [C_y_bits-1:0]     y_q, y_d;
  logic [C_data_len-1:0]   snap_q, snap_d;
  logic [C_color_bits-1:0] pix_q, pix_d;
  logic                    valid_q, valid_d;
  logic                    start_q, start_d;
  logic                    done_q, done_d;
  logic                    pending_q, pending_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    snap_d    = snap_q;
    pix_d     = pix_q;
    valid_d   = valid_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    pending_d = pending_q | (refresh & (state_q != IDLE));
    case (state_q)
      IDLE: if (refresh | pending_q) begin
        snap_d    = data_in;
        x_d       = '0;
        y_d       = '0;
        pending_d = 1'b0;
        cnt_d     = CNT_LOAD;
        start_d   = 1'b1;
        state_d   = SETTLE;
      end
      SETTLE: if (cnt_q == '0) begin
        pix_d   = color_in;
        valid_d = 1'b1;
        state_d = PRESENT;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      PRESENT: if (valid_q && pixel_ready) begin
        valid_d = 1'b0;
        cnt_d   = CNT_LOAD;
        state_d = SETTLE;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef HEX_SCAN_AUTO_REFRESH_EN
            pending_d = 1'b1;
`else
            pending_d = pending_q | refresh;
`endif
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      snap_q    <= '0;
      pix_q     <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      snap_q    <= snap_d;
      pix_q     <= pix_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end
  assign x           = x_q;
  assign y           = y_q;
  assign data_snap   = snap_q;
  assign pixel_data  = pix_q;
  assign pixel_valid = valid_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_hex_scan_sequencer.sv
// tb_hex_scan_sequencer: scoreboard bench for a 4x2 frame with 2-cycle settle and color_in = {y,x}.
module tb_hex_scan_sequencer;
  localparam int DL = 16, CB = 8, XB = 4, YB = 4, XS = 4, YS = 2, ST = 2;
  logic          clk = 1'b0, resetn = 1'b1, refresh = 1'b0, pixel_ready = 1'b1;
  logic [DL-1:0] data_in = '0;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic [DL-1:0] data_snap;
  logic [CB-1:0] color_in, pixel_data;
  logic          pixel_valid, frame_start, frame_done, busy;
  assign color_in = {y, x};
  always #5 clk = ~clk;
  hex_scan_sequencer #(
    .C_data_len(DL), .C_color_bits(CB), .C_x_bits(XB), .C_y_bits(YB),
    .C_x_size(XS), .C_y_size(YS), .C_settle(ST)
  ) dut (
    .clk(clk), .resetn(resetn), .data_in(data_in), .refresh(refresh),
    .x(x), .y(y), .data_snap(data_snap), .color_in(color_in),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );
  typedef struct {logic [CB-1:0] pix; int px; int py; int gap;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, last = 0;
  bit fin = 1'b0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // gap = expected negedges since frame_start or previous acceptance; 0 = unchecked
  task automatic push(int n, int hold_idx);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      int k;
      k = i % (XS * YS);
      e.px  = k % XS;
      e.py  = k / XS;
      e.pix = CB'(e.py * 16 + e.px);
      e.gap = (k == 0) ? ST : (k == hold_idx ? 0 : ST + 1);
      q.push_back(e);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!resetn) fin = 1'b0;
    else begin
      if (frame_done) begin
        check("done_after_last_pixel", fin, 1);
        fin = 1'b0;
      end
      if (frame_start) last = cyc;
      if (pixel_valid && pixel_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: unexpected pixel %0h at x=%0d y=%0d", pixel_data, x, y);
        end else begin
          e = q.pop_front();
          check("pixel_data", pixel_data, e.pix);
          check("pixel_x", x, e.px);
          check("pixel_y", y, e.py);
          if (e.gap != 0) check("pixel_spacing", cyc - last, e.gap);
        end
        last = cyc;
        fin = (x == XS - 1) && (y == YS - 1);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_refresh;
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask
  task automatic wait_done(string nm);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      hit = frame_done;
    end
    check(nm, hit, 1);
  endtask
  task automatic wait_px(int wx, int wy);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      @(negedge clk);
      hit = pixel_valid && x == wx && y == wy;
    end
    check("wait_pixel", hit, 1);
  endtask
  task automatic check_zero(string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_snap"}, data_snap, 0);
    check({tag, "_pix"}, pixel_data, 0);
    check({tag, "_valid"}, pixel_valid, 0);
    check({tag, "_start"}, frame_start, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    int s;
    #1 resetn = 1'b0;
    #10 check_zero("reset");
    #1 resetn = 1'b1;
    tick();
    push(8, -1);
    data_in = 16'h1234;
    pulse_refresh();
    @(negedge clk);
    check("t1_start", frame_start, 1);
    check("t1_snap", data_snap, 16'h1234);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_start_pulse", frame_start, 0);
    data_in = 16'hFFFF;
    wait_done("t1_done");
    check("t1_idle", busy, 0);
    check("snap_hold", data_snap, 16'h1234);
    @(negedge clk);
    check("t1_done_pulse", frame_done, 0);
    push(8, 2);
    pulse_refresh();
    @(negedge clk);
    check("t2_snap", data_snap, 16'hFFFF);
    wait_px(1, 0);
    tick();
    pixel_ready = 1'b0;
    wait_px(2, 0);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", pixel_valid, 1);
      check("bp_data", pixel_data, 8'h02);
      check("bp_x", x, 2);
      if (k < 4) @(negedge clk);
    end
    tick();
    pixel_ready = 1'b1;
    wait_done("t2_done");
    push(16, -1);
    pulse_refresh();
    wait_px(1, 0);
    pulse_refresh();
    wait_px(3, 0);
    pulse_refresh();
    wait_done("t3_done1");
    check("t3_gap_idle", busy, 0);
    @(negedge clk);
    check("t3_restart", frame_start, 1);
    check("t3_busy", busy, 1);
    wait_done("t3_done2");
    s = 0;
    repeat (12) begin
      @(negedge clk);
      s += int'(frame_start);
    end
    check("t3_single_extra", s, 0);
    check("t3_final_idle", busy, 0);
    push(5, -1);
    data_in = 16'h5A5A;
    pulse_refresh();
    wait_px(0, 1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 check_zero("midreset");
    s = 0;
    repeat (3) begin
      @(negedge clk);
      s += int'(frame_done);
    end
    check("midreset_no_done", s, 0);
    resetn = 1'b1;
    tick();
    check("midreset_drained", q.size(), 0);
    push(8, -1);
    data_in = 16'h0BAD;
    pulse_refresh();
    @(negedge clk);
    check("t4_snap", data_snap, 16'h0BAD);
    wait_done("t4_done");
    repeat (4) @(negedge clk);
    check("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hex_scan_sequencer.md
Name: hex_scan_sequencer

Overview:
Frame sequencer that drives the X/Y inputs of the hex display decoder and moves its colour output into a pixel-streaming display driver, such as the SPI OLED/LCD driver.
- At frame start it snapshots the data word, so digits cannot tear mid-frame.
- For each pixel it waits a programmable settle time for the decoder's combinational path before sampling the colour.
- It presents each pixel to the driver with a valid/ready handshake.
- It sits between the user data source, the hex decoder and the display driver.

Parameters:
C_data_len, 64, width of data word snapshotted and fed to the decoder
C_color_bits, 16, pixel colour width (8 = RGB332, 16 = RGB565)
C_x_bits, 7, width of x output
C_y_bits, 7, width of y output
C_x_size, 128, pixels per line; legal range 1..2^C_x_bits
C_y_size, 64, lines per frame; legal range 1..2^C_y_bits
C_settle, 2, cycles the decoder is given after x/y change before colour is sampled; must be >=1

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
data_in  in  C_data_len  live data to display
refresh  in  1  frame request pulse/level, sampled each clk
x  out  C_x_bits  pixel column to decoder
y  out  C_y_bits  pixel row to decoder
data_snap  out  C_data_len  frozen data to decoder
color_in  in  C_color_bits  colour returned by decoder (combinational from x, y, data_snap)
pixel_data  out  C_color_bits  colour to display driver
pixel_valid  out  1  pixel_data valid
pixel_ready  in  1  driver accepts pixel
frame_start  out  1  one-cycle pulse when a frame begins
frame_done  out  1  one-cycle pulse when the last pixel is accepted
busy  out  1  high in any state other than IDLE

Behaviour:
Reset (resetn low, asynchronous):
- state = IDLE; x, y, data_snap, pixel_data = 0.
- pixel_valid, frame_start, frame_done, busy, pending = 0.
- Reset mid-frame aborts immediately. No frame_done is produced.

States: IDLE, SETTLE, PRESENT.

IDLE:
- Trigger is refresh = 1 or pending = 1 at a clk edge. On that edge:
  - data_snap <= data_in; x <= 0; y <= 0; pending <= 0.
  - Settle counter <= C_settle - 1; frame_start = 1 for the next cycle.
  - Go to SETTLE.

SETTLE:
- Lasts exactly C_settle cycles.
- On the edge where the counter is 0: pixel_data <= color_in, pixel_valid <= 1, go to PRESENT.

PRESENT:
- pixel_data and pixel_valid stay stable until pixel_ready = 1.
- pixel_ready while pixel_valid = 0 is ignored.
- On an edge with pixel_valid & pixel_ready, pixel_valid <= 0, then:
  - If x = C_x_size-1 and y = C_y_size-1: x, y <= 0; frame_done = 1 for one cycle; go to IDLE.
  - Else if x = C_x_size-1: x <= 0, y <= y+1, reload counter, go to SETTLE.
  - Else: x <= x+1, reload counter, go to SETTLE.

Timing and ordering:
- First-pixel latency: pixel_valid rises C_settle edges after the edge that samples refresh.
- Peak throughput: one pixel per C_settle+1 cycles.
- Pixel order is raster: x fastest, then y.
- x and y change only on transitions into SETTLE.

refresh while busy:
- Sets sticky pending.
- A refresh in the same cycle as the frame_done transition also sets pending.
- A pending frame starts on the first IDLE cycle, so there is one IDLE cycle between frames.
- Multiple refreshes collapse into one frame.

Other rules:
- data_snap changes only on the frame-start edge. Changes on data_in mid-frame are not visible on data_snap.
- busy is combinational from state (state != IDLE).

Optional Feature:
HEX_SCAN_AUTO_REFRESH_EN
- Defined: on frame_done, pending is forced to 1, so the sequencer scans continuously with one IDLE cycle between frames. refresh is still accepted but has no further effect.
- Undefined: frames start only on refresh or pending, as above.

Test Plan:
(All with C_x_size=4, C_y_size=2, C_settle=2, color_in = {y,x} zero-extended; bench drives pixel_ready=1 unless stated.)
- Single frame: refresh for 1 cycle with data_in=0x1234 -> frame_start pulse; data_snap=0x1234; 8 pixels with pixel_data 0x00,01,02,03,10,11,12,13 (sampled {y,x}), each spaced 3 cycles; first valid 2 edges after refresh; then frame_done pulse and busy=0.
- Backpressure: pixel_ready=0 for 5 cycles on pixel 2 -> pixel_valid and pixel_data=0x02 stay stable; x stays 2; next pixel follows 3 cycles after acceptance.
- Snapshot hold: change data_in to 0xFFFF mid-frame -> data_snap stays 0x1234 until the next frame start.
- Pending: refresh pulsed twice during a frame -> exactly one further frame starts one IDLE cycle after frame_done.
- Reset mid-frame: resetn low during pixel 5 -> all outputs 0 immediately; no frame_done; next refresh restarts at x=0, y=0.
- With HEX_SCAN_AUTO_REFRESH_EN: one refresh -> back-to-back frames; frame_start 1 cycle after each frame_done.
